box_ctrl: RTL and testbench
===========================

# box_ctrl

Frame-synchronous controller for the box-drawing datapath. Accepts box requests from a detector through a valid/ready handshake, clamps them to the 768x576 image, and presents stable coordinates to `box_top`. Coordinates change only at frame boundaries, so a box never tears mid-frame. A hold counter blanks a box that has not been refreshed for a set number of frames.

## Interface
- `IMG_W`, default 768: image width in pixels.
- `IMG_H`, default 576: image height in pixels.
- `HOLD_FRAMES`, default 8: frames a box stays visible without a new request; range 1..255.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  box request present.
- `req_ready`  out  1  controller can accept a request.
- `req_x`, `req_y`, `req_width`, `req_height`  in  10 each  requested box, in pixels.
- `pix_valid`  in  1  one pixel accepted into `box_top` this cycle (`input_wr_en & ~input_full`).
- `x`, `y`, `width`, `height`  out  10 each  active box driven to `box_top`.
- `box_en`  out  1  box visible; when 0, `width` and `height` are driven as 0.
- `frame_start`  out  1  one-cycle pulse on the first cycle of each new frame's parameters.

## Operation
- Position counter: `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1, advancing only on `pix_valid`.
  - `boundary` = `pix_valid & col==IMG_W-1 & row==IMG_H-1`.
  - On `boundary`, both counters wrap to 0.
- Pending buffer (one entry): `req_ready = ~pend_valid`, combinational.
  - A handshake (`req_valid & req_ready`) stores the clamped request and sets `pend_valid`.
- Clamp (applied at accept; 11-bit unsigned arithmetic):
  - `cx = min(req_x, IMG_W-1)`, `cy = min(req_y, IMG_H-1)`.
  - `cw = min(req_width, IMG_W-cx)`, `ch = min(req_height, IMG_H-cy)`.
  - A request with `cw==0` or `ch==0` is a clear request.
- FSM has two states, IDLE (`box_en`=0) and SHOW (`box_en`=1). All transitions happen only on `boundary`:
  - `pend_valid` with a non-clear request: load the active registers, set `hold` = HOLD_FRAMES, go to SHOW, clear `pend_valid`.
  - `pend_valid` with a clear request: go to IDLE, clear `pend_valid`.
  - No pending request while in SHOW: decrement `hold`; when `hold` reaches 0 go to IDLE.
  - No pending request while in IDLE: no change.
- Active `x`/`y` keep their last values in IDLE; `width`/`height` outputs are forced to 0.

## Timing
- Reset values (asynchronous):
  - `x`, `y`, `width`, `height`, `box_en`, `frame_start` = 0.
  - `col`, `row`, `hold` = 0; `pend_valid` = 0, so `req_ready` = 1; state = IDLE.
- Request latency: accepted on cycle t, effective at the cycle after the next `boundary` at or after t+1.
- Outputs update, and `frame_start` pulses, exactly 1 cycle after the `boundary` cycle.
- Handshake and boundary on the same cycle:
  - If the pending buffer was empty, the new request is not committed this frame; it is stored and committed at the next boundary.
  - If the buffer was full, the commit happens and `req_ready` stays low that cycle; the buffer frees on the next cycle.
- `req_valid` held with `req_ready`=0: the request is not consumed; the requester must hold its data stable.
- `pix_valid` gaps stall the counters; nothing else changes.
- Reset asserted mid-frame: everything returns to reset values immediately, and the counter restarts at pixel 0 of the next accepted pixel.

## Structure
- Package `box_pkg`:
  - `IMG_W`/`IMG_H` defaults, `COORD_W`=10.
  - `box_t` struct {x, y, width, height}.
  - `box_state_t` enum {IDLE, SHOW}.
- Sub-module `box_clamp`: combinational `box_t` in/out, parameterized by `IMG_W`/`IMG_H`, instanced at the request port.
- Top-level `box_ctrl`: position counter, pending register, FSM, hold counter.

## Test plan
- Reset, then request (100,100,50,50) mid-frame 0 -> outputs stay 0 until 442368 pixels are accepted; next cycle `x`=100, `y`=100, `width`=50, `height`=50, `box_en`=1, `frame_start`=1.
- Request (740,560,100,100) -> committed `x`=740, `y`=560, `width`=28, `height`=16; request (900,700,5,5) -> `x`=767, `y`=575, `width`=1, `height`=1.
- HOLD_FRAMES=2, one request, then no more -> `box_en`=1 for frames 1-2, 0 from frame 3 on; `width`/`height` read 0.
- Second request while pending is full -> `req_ready`=0 until the boundary; the first request commits at that boundary, the second commits at the following one.
- Request handshake on the exact boundary cycle with an empty buffer -> not shown in the next frame; shown the frame after.
- Random `pix_valid` gaps plus reset asserted at pixel 1000 -> all outputs 0 at once; after release, a boundary occurs only after a fresh 442368 accepted pixels.

Source files
------------

// File: rtl/box_pkg.sv
// Shared types and geometry defaults for the box-drawing controller.
package box_pkg;
    localparam int COORD_W   = 10;
    localparam int DEF_IMG_W = 768;
    localparam int DEF_IMG_H = 576;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] width;
        logic [COORD_W-1:0] height;
    } box_t;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } box_state_t;
endpackage

// File: rtl/box_clamp.sv
// Clips a requested box to the image. Purely combinational, no flow control.
module box_clamp
    import box_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  box_t req,
    output box_t clamped,
    output logic clear
);
    localparam int CW1 = COORD_W + 1;
    localparam logic [CW1-1:0] FULL_W = CW1'(IMG_W);
    localparam logic [CW1-1:0] FULL_H = CW1'(IMG_H);
    localparam logic [CW1-1:0] MAX_X  = CW1'(IMG_W - 1);
    localparam logic [CW1-1:0] MAX_Y  = CW1'(IMG_H - 1);

    logic [CW1-1:0] cx, cy, room_w, room_h, cw, ch;

    // One extra bit so the remaining room (up to the full image size) never wraps.
    always_comb begin
        cx      = ({1'b0, req.x} > MAX_X) ? MAX_X : {1'b0, req.x};
        cy      = ({1'b0, req.y} > MAX_Y) ? MAX_Y : {1'b0, req.y};
        room_w  = FULL_W - cx;
        room_h  = FULL_H - cy;
        cw      = ({1'b0, req.width}  > room_w) ? room_w : {1'b0, req.width};
        ch      = ({1'b0, req.height} > room_h) ? room_h : {1'b0, req.height};
        clamped.x      = COORD_W'(cx);
        clamped.y      = COORD_W'(cy);
        clamped.width  = COORD_W'(cw);
        clamped.height = COORD_W'(ch);
        clear          = (cw == '0) || (ch == '0);
    end
endmodule

// File: rtl/box_ctrl.sv
// Frame-synchronous box controller: requests commit at the next frame boundary, outputs move 1 cycle after it.
// One-entry pending buffer; req_ready drops while it is full and frees on the boundary that commits it.
module box_ctrl
    import box_pkg::*;
#(
    parameter int IMG_W       = DEF_IMG_W,
    parameter int IMG_H       = DEF_IMG_H,
    parameter int HOLD_FRAMES = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    input  logic [COORD_W-1:0] req_width,
    input  logic [COORD_W-1:0] req_height,
    input  logic               pix_valid,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] width,
    output logic [COORD_W-1:0] height,
    output logic               box_en,
    output logic               frame_start
);
    localparam logic [COORD_W-1:0] LAST_COL  = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(IMG_H - 1);
    localparam logic [7:0]         HOLD_INIT = 8'(HOLD_FRAMES);

    logic [COORD_W-1:0] col, row;
    logic               boundary;
    logic               handshake;
    box_t               req_box, req_clamped, pend, act;
    logic               req_clear, pend_clear, pend_valid;
    box_state_t         state_q, state_d;
    logic [7:0]         hold_q, hold_d;
    logic               load;

    assign boundary  = pix_valid && (col == LAST_COL) && (row == LAST_ROW);
    assign req_ready = ~pend_valid;
    assign handshake = req_valid && req_ready;
    assign req_box   = {req_x, req_y, req_width, req_height};

    box_clamp #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_clamp (
        .req     (req_box),
        .clamped (req_clamped),
        .clear   (req_clear)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // A handshake needs an empty buffer, so it can never collide with a commit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend       <= '0;
            pend_clear <= 1'b0;
        end else if (handshake) begin
            pend_valid <= 1'b1;
            pend       <= req_clamped;
            pend_clear <= req_clear;
        end else if (boundary) begin
            pend_valid <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        load    = 1'b0;
        if (boundary) begin
            if (pend_valid) begin
                if (pend_clear) begin
                    state_d = IDLE;
                end else begin
                    state_d = SHOW;
                    hold_d  = HOLD_INIT;
                    load    = 1'b1;
                end
            end else if (state_q == SHOW) begin
                hold_d = hold_q - 8'd1;
                if (hold_d == 8'd0) begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            act         <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            frame_start <= boundary;
            if (load) begin
                act <= pend;
            end
        end
    end

    // Position survives a blank period; only the extent is zeroed.
    assign box_en = (state_q == SHOW);
    assign x      = act.x;
    assign y      = act.y;
    assign width  = box_en ? act.width  : '0;
    assign height = box_en ? act.height : '0;
endmodule

// File: tb/tb_box_ctrl.sv
// Scoreboard bench for box_ctrl on a reduced image so many frames fit in a short run.
module tb_box_ctrl;
    import box_pkg::*;

    localparam int W     = 24;
    localparam int H     = 16;
    localparam int HOLD  = 2;
    localparam int FRAME = W * H;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [9:0]   req_x = '0, req_y = '0, req_width = '0, req_height = '0;
    logic         pix_valid = 1'b0;
    logic [9:0]   x, y, width, height;
    logic         box_en, frame_start;

    int total = 0;
    int bad   = 0;
    bit pix_mode = 1'b0;

    // reference model state
    int          m_pcount = 0;
    int          m_acc    = 0;
    int          m_frames = 0;
    box_t        m_pend[$];
    box_t        m_act;
    box_t        mb;
    bit          m_vis = 1'b0;
    int          m_hold = 0;
    bit          m_hs, m_bnd;
    logic [40:0] exq[$];
    logic [40:0] cur;

    always #5 clock = ~clock;

    box_ctrl #(.IMG_W(W), .IMG_H(H), .HOLD_FRAMES(HOLD)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_width   (req_width),
        .req_height  (req_height),
        .pix_valid   (pix_valid),
        .x           (x),
        .y           (y),
        .width       (width),
        .height      (height),
        .box_en      (box_en),
        .frame_start (frame_start)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic box_t ref_clamp(input int rx, input int ry, input int rw, input int rh);
        int   cx, cy, cw, ch;
        box_t b;
        cx = (rx < W) ? rx : W - 1;
        cy = (ry < H) ? ry : H - 1;
        cw = (rw < W - cx) ? rw : W - cx;
        ch = (rh < H - cy) ? rh : H - cy;
        b.x = 10'(cx); b.y = 10'(cy); b.width = 10'(cw); b.height = 10'(ch);
        return b;
    endfunction

    // Model: a frame is FRAME accepted pixels; a request waits in a one-deep queue for the next frame end.
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_pcount = 0; m_acc = 0; m_pend.delete(); m_act = '0;
            m_vis = 1'b0; m_hold = 0; exq.delete();
        end else begin
            m_hs  = req_valid && (m_pend.size() == 0);
            m_bnd = pix_valid && (m_pcount == FRAME - 1);
            if (m_bnd) begin
                if (m_pend.size() != 0) begin
                    mb = m_pend.pop_front();
                    if (mb.width == 0 || mb.height == 0) begin
                        m_vis = 1'b0;
                    end else begin
                        m_act = mb; m_vis = 1'b1; m_hold = HOLD;
                    end
                end else if (m_vis) begin
                    m_hold--;
                    if (m_hold == 0) m_vis = 1'b0;
                end
                exq.push_back({m_vis, m_act.x, m_act.y,
                               m_vis ? m_act.width : 10'd0, m_vis ? m_act.height : 10'd0});
                m_frames++;
            end
            if (m_hs) m_pend.push_back(ref_clamp(int'(req_x), int'(req_y), int'(req_width), int'(req_height)));
            if (pix_valid) begin
                m_acc++;
                m_pcount = (m_pcount + 1) % FRAME;
            end
        end
    end

    // Monitor: each frame_start must match a queued expectation; outputs must hold between them.
    initial begin
        cur = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                cur = '0;
            end else begin
                chk("frame_start", 64'(frame_start), 64'(exq.size() != 0));
                if (exq.size() != 0) cur = exq.pop_front();
                chk("outputs", 64'({box_en, x, y, width, height}), 64'(cur));
                chk("req_ready", 64'(req_ready), 64'(m_pend.size() == 0));
            end
        end
    end

    task automatic tick();
        pix_valid = pix_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
        @(negedge clock);
    endtask

    task automatic send(input int rx, input int ry, input int rw, input int rh);
        bit acc = 1'b0;
        req_x = 10'(rx); req_y = 10'(ry); req_width = 10'(rw); req_height = 10'(rh);
        req_valid = 1'b1;
        for (int n = 0; n < FRAME * 4 && !acc; n++) begin
            acc = req_ready;
            tick();
        end
        req_valid = 1'b0;
        chk("send accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_frames(input int k);
        int target = m_frames + k;
        int n = 0;
        while (m_frames < target && n < FRAME * 4 * k) begin
            tick();
            n++;
        end
        chk("frame timeout", 64'(m_frames >= target), 64'd1);
    endtask

    task automatic chk_box(input string nm, input logic [40:0] exp);
        chk(nm, 64'({box_en, x, y, width, height}), 64'(exp));
    endtask

    initial begin
        int mark;
        int n;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset outputs", 64'({box_en, x, y, width, height, frame_start}), 64'd0);
        chk("reset ready", 64'(req_ready), 64'd1);
        reset = 1'b0;

        repeat (50) tick();
        send(10, 10, 5, 5);
        wait_frames(1);
        chk_box("first box", {1'b1, 10'd10, 10'd10, 10'd5, 10'd5});

        send(22, 14, 10, 10);
        wait_frames(1);
        chk_box("clamp edge", {1'b1, 10'd22, 10'd14, 10'd2, 10'd2});
        send(900, 700, 5, 5);
        wait_frames(1);
        chk_box("clamp over", {1'b1, 10'd23, 10'd15, 10'd1, 10'd1});
        wait_frames(1);
        chk_box("hold frame 2", {1'b1, 10'd23, 10'd15, 10'd1, 10'd1});
        wait_frames(1);
        chk_box("hold expired", {1'b0, 10'd23, 10'd15, 10'd0, 10'd0});

        send(1, 2, 3, 4);
        send(5, 6, 7, 8);
        chk_box("first of two", {1'b1, 10'd1, 10'd2, 10'd3, 10'd4});
        wait_frames(1);
        chk_box("second of two", {1'b1, 10'd5, 10'd6, 10'd7, 10'd8});

        pix_mode = 1'b1;
        n = 0;
        while (m_pcount != FRAME - 1 && n < FRAME * 2) begin
            tick();
            n++;
        end
        req_x = 10'd9; req_y = 10'd9; req_width = 10'd3; req_height = 10'd3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk_box("boundary req deferred", {1'b1, 10'd5, 10'd6, 10'd7, 10'd8});
        wait_frames(1);
        chk_box("boundary req shown", {1'b1, 10'd9, 10'd9, 10'd3, 10'd3});
        pix_mode = 1'b0;

        send(3, 3, 0, 4);
        wait_frames(1);
        chk_box("clear request", {1'b0, 10'd9, 10'd9, 10'd0, 10'd0});

        for (int i = 0; i < 20; i++) begin
            send(($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 30),
                 ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 20),
                 $urandom_range(0, 15), $urandom_range(0, 15));
            repeat ($urandom_range(0, 500)) tick();
        end

        mark = m_acc;
        n = 0;
        while (!(m_acc - mark >= 1000 && m_pcount inside {[10:FRAME-10]}) && n < 5000) begin
            tick();
            n++;
        end
        reset = 1'b1;
        #1;
        chk("mid-frame reset outputs", 64'({box_en, x, y, width, height, frame_start}), 64'd0);
        chk("mid-frame reset ready", 64'(req_ready), 64'd1);
        repeat (3) tick();
        reset = 1'b0;
        send(4, 4, 4, 4);
        wait_frames(1);
        chk_box("after reset", {1'b1, 10'd4, 10'd4, 10'd4, 10'd4});

        repeat (5) tick();
        chk("scoreboard drained", 64'(exq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
